// File: rtl/rim_loader.sv
// RIM paper-tape loader: leader hunt, 12-bit word assembly, RAM writes one cycle after the low byte.
// No backpressure: every strobed byte is consumed or dropped. RIM_LOADER_AUTOSTART_EN adds startPC/startPulse.
module rim_loader #(
    parameter int unsigned LEADER_MIN     = 8,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd12000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        arm,
    input  logic [7:0]  rxData,
    input  logic        rxValid,
    output logic [11:0] ramAddr,
    output logic [11:0] ramData,
    output logic        ramWe,
    output logic        loading,
    output logic        done,
    output logic        err,
    output logic [11:0] wordCount
`ifdef RIM_LOADER_AUTOSTART_EN
    ,
    output logic [11:0] startPC,
    output logic        startPulse
`endif
);

    localparam int LCW = $clog2(LEADER_MIN + 1);
    localparam logic [LCW-1:0] LMIN = LCW'(LEADER_MIN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEADER,
        S_HI,
        S_LO,
        S_DONE,
        S_ERR
    } state_t;

    state_t         state_q;
    logic [LCW-1:0] leader_cnt_q;
    logic           is_addr_q;
    logic [5:0]     hi6_q;
    logic [11:0]    cur_addr_q;
    logic           addr_valid_q;
    logic [23:0]    tmr_q;
    logic [11:0]    ram_addr_q;
    logic [11:0]    ram_data_q;
    logic           ram_we_q;
    logic           loading_q;
    logic           done_q;
    logic           err_q;
    logic [11:0]    word_cnt_q;

    logic        is_leader_byte;
    logic        timed_out;
    logic [11:0] word;

    always_comb begin
        is_leader_byte = (rxData == 8'o200);
        timed_out      = (tmr_q >= TIMEOUT_CYCLES - 24'd1);
        word           = {hi6_q, rxData[5:0]};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            leader_cnt_q <= '0;
            is_addr_q    <= 1'b0;
            hi6_q        <= '0;
            cur_addr_q   <= '0;
            addr_valid_q <= 1'b0;
            tmr_q        <= '0;
            ram_addr_q   <= '0;
            ram_data_q   <= '0;
            ram_we_q     <= 1'b0;
            loading_q    <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            word_cnt_q   <= '0;
        end else begin
            ram_we_q <= 1'b0;
            if (arm) begin
                // A byte strobed together with arm is deliberately dropped.
                state_q      <= S_LEADER;
                leader_cnt_q <= '0;
                word_cnt_q   <= '0;
                addr_valid_q <= 1'b0;
                done_q       <= 1'b0;
                err_q        <= 1'b0;
                loading_q    <= 1'b1;
                tmr_q        <= '0;
            end else begin
                case (state_q)
                    S_LEADER: begin
                        if (rxValid) begin
                            if (is_leader_byte) begin
                                if (leader_cnt_q < LMIN) leader_cnt_q <= leader_cnt_q + LCW'(1);
                            end else if (leader_cnt_q < LMIN) begin
                                leader_cnt_q <= '0;
                            end else if (rxData[7]) begin
                                state_q   <= S_ERR;
                                err_q     <= 1'b1;
                                loading_q <= 1'b0;
                            end else begin
                                // Leader is long enough: this byte is the first frame's high half.
                                is_addr_q <= rxData[6];
                                hi6_q     <= rxData[5:0];
                                tmr_q     <= '0;
                                state_q   <= S_LO;
                            end
                        end
                    end
                    S_HI: begin
                        if (rxValid) begin
                            tmr_q <= '0;
                            if (is_leader_byte) begin
                                state_q   <= S_DONE;
                                done_q    <= 1'b1;
                                loading_q <= 1'b0;
                            end else if (rxData[7]) begin
                                state_q   <= S_ERR;
                                err_q     <= 1'b1;
                                loading_q <= 1'b0;
                            end else begin
                                is_addr_q <= rxData[6];
                                hi6_q     <= rxData[5:0];
                                state_q   <= S_LO;
                            end
                        end else if (timed_out) begin
                            state_q   <= S_ERR;
                            err_q     <= 1'b1;
                            loading_q <= 1'b0;
                        end else begin
                            tmr_q <= tmr_q + 24'd1;
                        end
                    end
                    S_LO: begin
                        if (rxValid) begin
                            tmr_q <= '0;
                            if (rxData[7:6] != 2'b00 || (!is_addr_q && !addr_valid_q)) begin
                                state_q   <= S_ERR;
                                err_q     <= 1'b1;
                                loading_q <= 1'b0;
                            end else if (is_addr_q) begin
                                cur_addr_q   <= word;
                                addr_valid_q <= 1'b1;
                                state_q      <= S_HI;
                            end else begin
                                ram_addr_q <= cur_addr_q;
                                ram_data_q <= word;
                                ram_we_q   <= 1'b1;
                                cur_addr_q <= cur_addr_q + 12'd1;
                                if (word_cnt_q != 12'o7777) word_cnt_q <= word_cnt_q + 12'd1;
                                state_q    <= S_HI;
                            end
                        end else if (timed_out) begin
                            state_q   <= S_ERR;
                            err_q     <= 1'b1;
                            loading_q <= 1'b0;
                        end else begin
                            tmr_q <= tmr_q + 24'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign ramAddr   = ram_addr_q;
    assign ramData   = ram_data_q;
    assign ramWe     = ram_we_q;
    assign loading   = loading_q;
    assign done      = done_q;
    assign err       = err_q;
    assign wordCount = word_cnt_q;

`ifdef RIM_LOADER_AUTOSTART_EN
    logic [11:0] start_pc_q;
    logic        start_pulse_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            start_pc_q    <= '0;
            start_pulse_q <= 1'b0;
        end else begin
            start_pulse_q <= !arm && rxValid && state_q == S_HI && is_leader_byte && addr_valid_q;
            // First address frame of the load is the one seen while no address is yet valid.
            if (!arm && rxValid && state_q == S_LO && rxData[7:6] == 2'b00 && is_addr_q && !addr_valid_q)
                start_pc_q <= word;
        end
    end

    assign startPC    = start_pc_q;
    assign startPulse = start_pulse_q;
`endif

endmodule
